cla_seq_adder: RTL and testbench
================================

// Module: cla_seq_adder
// PURPOSE
//   Multi-cycle carry-lookahead adder that consumes per-bit generate/propagate terms.
//   Each operand word is split into GROUP-bit slices. One slice is resolved per clock:
//   a lookahead carry unit turns the slice's g/p bits and the incoming carry into slice
//   carries, sums and a group G/P. The carry then ripples slice-to-slice across cycles.
//   The block sits between an operand producer and a result consumer, using a
//   valid/ready handshake on both sides.
// PARAMETERS
//   WIDTH   16  operand/sum width in bits; must be a multiple of GROUP
//   GROUP   4   slice width resolved per cycle by the lookahead unit
// PORTS
//   clk        in   1      single clock; all state changes on the rising edge
//   rst_n      in   1      asynchronous reset, active low
//   valid_i    in   1      operand request valid
//   ready_o    out  1      block can accept operands
//   a_i        in   WIDTH  operand x
//   b_i        in   WIDTH  operand y
//   c_i        in   1      carry in
//   valid_o    out  1      result valid
//   ready_i    in   1      consumer accepts result
//   s_o        out  WIDTH  sum
//   c_o        out  1      carry out of MSB
//   ovf_o      out  1      two's-complement overflow (carry into MSB ^ carry out of MSB)
//   grp_g_o    out  1      word-level generate: carry out irrespective of c_i
//   grp_p_o    out  1      word-level propagate: all bits propagate (a_i ^ b_i all ones)
// BEHAVIOUR
//   Per-bit terms: g = a & b, p = a ^ b, s = p ^ carry-in of that bit.
//   Slice carries: c[j+1] = g[j] | p[j]&c[j], flattened as lookahead (no ripple inside slice).
//   Reset (rst_n=0, async): state=IDLE; ready_o=1; valid_o=0; s_o, c_o, ovf_o,
//     grp_g_o, grp_p_o = 0; slice index = 0; operand/carry registers = 0.
//   States:
//     IDLE: ready_o=1. On valid_i&ready_o, latch a_i/b_i/c_i, set idx=0 -> CALC.
//     CALC: ready_o=0. Each cycle resolve slice idx:
//       - write s_o[idx*GROUP +: GROUP];
//       - update carry register;
//       - accumulate word G/P: G = Gs | Ps&G_prev, P = Ps & P_prev
//         (G starts 0, P starts 1).
//       When idx = WIDTH/GROUP-1, register c_o, ovf_o, grp_g_o, grp_p_o -> DONE;
//       otherwise idx++.
//     DONE: valid_o=1, ready_o=0; all result outputs stable.
//       On ready_i, go to IDLE with valid_o=0 the next cycle.
//   Latency: accept at edge T -> valid_o high after edge T+WIDTH/GROUP
//     (4 cycles at defaults). Throughput: one result per WIDTH/GROUP+2 cycles minimum.
//   Result outputs hold their last value in IDLE/CALC until overwritten.
//     Consumers sample only when valid_o=1.
//   valid_i while ready_o=0 is ignored; the producer must hold the request.
//   a_i/b_i/c_i changes after acceptance have no effect.
//   ready_i outside DONE is ignored. No result is ever dropped or duplicated.
//   Reset mid-CALC or mid-DONE aborts the operation; there is no output for it.
//     After rst_n rises, the first accept starts cleanly.
//   WIDTH % GROUP != 0 is illegal and must fail elaboration.
//   WIDTH == GROUP is legal (one CALC cycle).
//   Arithmetic is modulo 2^WIDTH; the carry beyond WIDTH appears only on c_o.
// TESTING
//   1) 0x1234 + 0x4321, c_i=0 -> s_o=0x5555, c_o=0, ovf_o=0, valid_o exactly 4 cycles after accept.
//   2) 0xFFFF + 0x0001, c_i=0 -> s_o=0x0000, c_o=1, ovf_o=0, grp_g_o=1.
//      0xFFFF + 0x0000, c_i=1 -> s_o=0, c_o=1, grp_p_o=1, grp_g_o=0.
//   3) 0x7FFF + 0x0001 -> s_o=0x8000, ovf_o=1, c_o=0.
//      0x8000 + 0x8000 -> s_o=0, c_o=1, ovf_o=1.
//   4) Backpressure: hold ready_i=0 for 6 cycles in DONE -> valid_o and s_o stable,
//      ready_o=0, valid_i pulses ignored; ready_i=1 -> IDLE next cycle, ready_o=1.
//   5) Assert rst_n=0 during CALC slice 2 -> outputs immediately return to reset values;
//      the next op, 0x00FF + 0x0001, gives 0x0100 with normal latency.
//   6) Back-to-back: valid_i held high with ready_i=1 over 100 random operand sets
//      -> every s_o/c_o matches a reference model, in order, none lost.

Source files
------------

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder. Operands are latched on a valid/ready
// handshake. The word is then resolved one GROUP-bit slice per clock, LSB
// slice first. A lookahead unit flattens each slice's carries, and the slice
// carry-out ripples into the next slice on the following cycle. The result is
// held in DONE until the consumer takes it.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   valid_i / ready_o    operand handshake (a_i, b_i, c_i)
//   valid_o / ready_i    result handshake (s_o, c_o, ovf_o, grp_g_o, grp_p_o)
//   ovf_o                two's-complement overflow
//   grp_g_o / grp_p_o    word-level generate / propagate

// One slice of lookahead: carries, sum, and group generate/propagate.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] g_i,
  input  logic [GROUP-1:0] p_i,
  input  logic             c_i,
  output logic [GROUP-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o,  // carry into the slice's top bit
  output logic             g_o,
  output logic             p_o
);
  // Carry into bit j as a flat sum of products:
  //   cin&p[0..j-1] | g[0]&p[1..j-1] | ... | g[j-1]
  function automatic logic carry_at(input logic [GROUP-1:0] g,
                                    input logic [GROUP-1:0] p,
                                    input logic cin, input int j);
    logic [GROUP:0] gx;
    logic           t;
    logic           c;
    gx = {g, cin};
    c  = 1'b0;
    for (int k = 0; k <= j; k++) begin
      t = gx[k];
      for (int m = k; m < j; m++) t = t & p[m];
      c = c | t;
    end
    return c;
  endfunction

  logic [GROUP:0] c;

  always_comb begin
    c = '0;
    for (int j = 0; j <= GROUP; j++) c[j] = carry_at(g_i, p_i, c_i, j);
  end

  assign s_o     = p_i ^ c[GROUP-1:0];
  assign c_o     = c[GROUP];
  assign c_msb_o = c[GROUP-1];
  assign g_o     = carry_at(g_i, p_i, 1'b0, GROUP);
  assign p_o     = &p_i;
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             grp_g_o,
  output logic             grp_p_o
);
  localparam int NSL = WIDTH / GROUP;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of GROUP");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic             cy_q;           // carry into the current slice
  logic [IW-1:0]    idx;
  logic             gacc_q, pacc_q; // word G/P over slices resolved so far

  logic [GROUP-1:0] a_sl, b_sl, s_sl;
  logic             c_sl, c_sl_msb, g_sl, p_sl;
  logic             last;

  assign a_sl = a_q[int'(idx)*GROUP +: GROUP];
  assign b_sl = b_q[int'(idx)*GROUP +: GROUP];
  assign last = (idx == IW'(NSL-1));

  cla_group #(.GROUP(GROUP)) u_grp (
    .g_i     (a_sl & b_sl),
    .p_i     (a_sl ^ b_sl),
    .c_i     (cy_q),
    .s_o     (s_sl),
    .c_o     (c_sl),
    .c_msb_o (c_sl_msb),
    .g_o     (g_sl),
    .p_o     (p_sl)
  );

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid_i)  state_nx = CALC;
      CALC:    if (last)     state_nx = DONE;
      DONE:    if (ready_i)  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      idx     <= '0;
      gacc_q  <= 1'b0;
      pacc_q  <= 1'b0;
      s_o     <= '0;
      c_o     <= 1'b0;
      ovf_o   <= 1'b0;
      grp_g_o <= 1'b0;
      grp_p_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          a_q    <= a_i;
          b_q    <= b_i;
          cy_q   <= c_i;
          idx    <= '0;
          gacc_q <= 1'b0;
          pacc_q <= 1'b1;
        end
        CALC: begin
          s_o[int'(idx)*GROUP +: GROUP] <= s_sl;
          cy_q   <= c_sl;
          gacc_q <= g_sl | (p_sl & gacc_q);
          pacc_q <= p_sl & pacc_q;
          if (last) begin
            c_o     <= c_sl;
            // top slice carries: into MSB vs out of MSB
            ovf_o   <= c_sl_msb ^ c_sl;
            grp_g_o <= g_sl | (p_sl & gacc_q);
            grp_p_o <= p_sl & pacc_q;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        c_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [15:0] s_o;
  logic        c_o, ovf_o, grp_g_o, grp_p_o;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] r_s;
  logic        r_c, r_ovf, r_gg, r_gp;
  int          r_lat;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .valid_o(valid_o), .ready_i(ready_i),
    .s_o(s_o), .c_o(c_o), .ovf_o(ovf_o), .grp_g_o(grp_g_o), .grp_p_o(grp_p_o)
  );

  // Stimulus only: issue one op from IDLE (called at posedge+1), capture the
  // result and latency, optionally hand the result back.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input bit rel);
    valid_i = 1'b1; a_i = a; b_i = b; c_i = c;
    @(posedge clk); #1;
    valid_i = 1'b0;
    r_lat = 0;
    while (!valid_o && r_lat < 20) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_s = s_o; r_c = c_o; r_ovf = ovf_o; r_gg = grp_g_o; r_gp = grp_p_o;
    if (rel) begin
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
    end
  endtask

  task automatic test_reset;
    nvec++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", ready_o); end
    nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid_o); end
    nvec++; if (s_o !== 16'h0) begin nerr++; $display("FAIL reset_s got %h want 0000", s_o); end
    nvec++; if ({c_o, ovf_o, grp_g_o, grp_p_o} !== 4'b0) begin
      nerr++; $display("FAIL reset_flags got %b want 0000", {c_o, ovf_o, grp_g_o, grp_p_o});
    end
  endtask

  task automatic test_basic;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1);
    nvec++; if (r_s !== 16'h5555) begin nerr++; $display("FAIL basic_s got %h want 5555", r_s); end
    nvec++; if (r_c !== 1'b0) begin nerr++; $display("FAIL basic_c got %b want 0", r_c); end
    nvec++; if (r_ovf !== 1'b0) begin nerr++; $display("FAIL basic_ovf got %b want 0", r_ovf); end
    nvec++; if (r_lat != 4) begin nerr++; $display("FAIL basic_latency got %0d want 4", r_lat); end
    nvec++; if ({r_gg, r_gp} !== 2'b00) begin nerr++; $display("FAIL basic_gp got %b want 00", {r_gg, r_gp}); end
  endtask

  task automatic test_carry;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    nvec++; if (r_s !== 16'h0000) begin nerr++; $display("FAIL carry1_s got %h want 0000", r_s); end
    nvec++; if (r_c !== 1'b1) begin nerr++; $display("FAIL carry1_c got %b want 1", r_c); end
    nvec++; if (r_ovf !== 1'b0) begin nerr++; $display("FAIL carry1_ovf got %b want 0", r_ovf); end
    nvec++; if (r_gg !== 1'b1) begin nerr++; $display("FAIL carry1_g got %b want 1", r_gg); end
    nvec++; if (r_gp !== 1'b0) begin nerr++; $display("FAIL carry1_p got %b want 0", r_gp); end
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    nvec++; if (r_s !== 16'h0000) begin nerr++; $display("FAIL carry2_s got %h want 0000", r_s); end
    nvec++; if (r_c !== 1'b1) begin nerr++; $display("FAIL carry2_c got %b want 1", r_c); end
    nvec++; if (r_gp !== 1'b1) begin nerr++; $display("FAIL carry2_p got %b want 1", r_gp); end
    nvec++; if (r_gg !== 1'b0) begin nerr++; $display("FAIL carry2_g got %b want 0", r_gg); end
  endtask

  task automatic test_ovf;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    nvec++; if (r_s !== 16'h8000) begin nerr++; $display("FAIL ovf1_s got %h want 8000", r_s); end
    nvec++; if (r_ovf !== 1'b1) begin nerr++; $display("FAIL ovf1_ovf got %b want 1", r_ovf); end
    nvec++; if (r_c !== 1'b0) begin nerr++; $display("FAIL ovf1_c got %b want 0", r_c); end
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1);
    nvec++; if (r_s !== 16'h0000) begin nerr++; $display("FAIL ovf2_s got %h want 0000", r_s); end
    nvec++; if (r_c !== 1'b1) begin nerr++; $display("FAIL ovf2_c got %b want 1", r_c); end
    nvec++; if (r_ovf !== 1'b1) begin nerr++; $display("FAIL ovf2_ovf got %b want 1", r_ovf); end
  endtask

  task automatic test_backpressure;
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    nvec++; if (r_s !== 16'h3333) begin nerr++; $display("FAIL bp_s got %h want 3333", r_s); end
    for (int i = 0; i < 6; i++) begin
      valid_i = i[0]; a_i = 16'hABCD; b_i = 16'h1357; c_i = 1'b1;
      @(posedge clk); #1;
      nvec++; if (valid_o !== 1'b1) begin nerr++; $display("FAIL bp_valid cyc %0d got %b want 1", i, valid_o); end
      nvec++; if (s_o !== 16'h3333) begin nerr++; $display("FAIL bp_hold cyc %0d got %h want 3333", i, s_o); end
      nvec++; if (ready_o !== 1'b0) begin nerr++; $display("FAIL bp_ready cyc %0d got %b want 0", i, ready_o); end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL bp_release_valid got %b want 0", valid_o); end
    nvec++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL bp_release_ready got %b want 1", ready_o); end
    // a pulse ignored in DONE must not have started another op
    @(posedge clk); #1;
    nvec++; if ({ready_o, valid_o} !== 2'b10) begin
      nerr++; $display("FAIL bp_no_extra got rdy/vld %b want 10", {ready_o, valid_o});
    end
  endtask

  task automatic test_reset_mid;
    valid_i = 1'b1; a_i = 16'hAAAA; b_i = 16'h5555; c_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;  // slices 0,1 written; slice 2 in progress
    rst_n = 1'b0;
    #1;
    nvec++; if (s_o !== 16'h0) begin nerr++; $display("FAIL midrst_s got %h want 0000", s_o); end
    nvec++; if ({ready_o, valid_o} !== 2'b10) begin
      nerr++; $display("FAIL midrst_hs got rdy/vld %b want 10", {ready_o, valid_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
    nvec++; if (r_s !== 16'h0100) begin nerr++; $display("FAIL midrst_next_s got %h want 0100", r_s); end
    nvec++; if (r_lat != 4) begin nerr++; $display("FAIL midrst_next_lat got %0d want 4", r_lat); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [100];
    logic [15:0] vb [100];
    logic        vc [100];
    logic [16:0] exp_sum [100];
    for (int i = 0; i < 100; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
      exp_sum[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {16'b0, vc[i]};
    end
    ready_i = 1'b1;
    fork
      begin : producer
        int cyc = 0;
        for (int i = 0; i < 100 && cyc < 3000; i++) begin
          logic acc;
          valid_i = 1'b1; a_i = va[i]; b_i = vb[i]; c_i = vc[i];
          do begin
            @(negedge clk); acc = ready_o;
            @(posedge clk); #1;
            cyc++;
          end while (!acc && cyc < 3000);
        end
        valid_i = 1'b0;
      end
      begin : monitor
        int j = 0;
        int cyc = 0;
        while (j < 100 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (valid_o && ready_i) begin
            nvec++; if (s_o !== exp_sum[j][15:0]) begin
              nerr++; $display("FAIL b2b_s op %0d got %h want %h", j, s_o, exp_sum[j][15:0]);
            end
            nvec++; if (c_o !== exp_sum[j][16]) begin
              nerr++; $display("FAIL b2b_c op %0d got %b want %b", j, c_o, exp_sum[j][16]);
            end
            j++;
          end
        end
        nvec++; if (j != 100) begin nerr++; $display("FAIL b2b_count got %0d want 100", j); end
      end
    join
    ready_i = 1'b0;
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_carry;
    test_ovf;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
